// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, write-source encodings,
// FSM state codes, the decoded control bundle and the immediate extender.
package decode_stage_pkg;

  // Opcode field instr[7:4]
  localparam logic [3:0] OP_CPIN  = 4'h6;
  localparam logic [3:0] OP_CPOUT = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;
  localparam logic [3:0] OP_BR    = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Register write-back source select
  localparam logic [1:0] WS_ALU = 2'd0;
  localparam logic [1:0] WS_MEM = 2'd1;
  localparam logic [1:0] WS_IMM = 2'd2;
  localparam logic [1:0] WS_COP = 2'd3;

  // Hazard FSM states
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_BR_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  // Control bundle handed to the ID/EX register
  typedef struct packed {
    logic       cpin;
    logic       cpout;
    logic       mem_read;
    logic       mem_write;
    logic       halt;
    logic       branch;
    logic       jump;
    logic       reg_write;
    logic [1:0] write_src;
  } ctrl_t;

  // Format-1 immediate is instr[3:0]; bit 3 doubles as the sign flag, so
  // sign-extension and zero-extension differ only when it is set.
  function automatic logic [15:0] extend_imm(input logic fmt, input logic [3:0] imm);
    if (fmt) begin
      return {{12{imm[3]}}, imm};
    end
    return 16'h0000;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between fetch/EX and the decode stage. The master side drives the
// fetched instruction and EX feedback; the slave (decode) side drives the
// ID/EX control, data fields, hazard outputs and counters.
interface decode_stage_if;
  logic [8:0]  in_instr;
  logic        in_instr_valid;
  logic        in_ex_memRead;
  logic [2:0]  in_ex_operand;
  logic        in_ex_resolved;

  logic        out_ctrl_cpin;
  logic        out_ctrl_cpout;
  logic        out_ctrl_memRead;
  logic        out_ctrl_memWrite;
  logic        out_ctrl_halt;
  logic        out_ctrl_branch;
  logic        out_ctrl_jump;
  logic        out_ctrl_regWrite;
  logic [1:0]  out_ctrl_writeSrc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_operand;
  logic        out_sign;
  logic        out_format;
  logic [15:0] out_extended;
  logic        out_flush;
  logic        out_if_stall;
  logic        out_halted;
  logic        out_br_timeout;
  logic [15:0] out_instr_count;
  logic [15:0] out_stall_count;

  modport master (
    output in_instr, in_instr_valid, in_ex_memRead, in_ex_operand, in_ex_resolved,
    input  out_ctrl_cpin, out_ctrl_cpout, out_ctrl_memRead, out_ctrl_memWrite,
           out_ctrl_halt, out_ctrl_branch, out_ctrl_jump, out_ctrl_regWrite,
           out_ctrl_writeSrc, out_opcode, out_operand, out_sign, out_format,
           out_extended, out_flush, out_if_stall, out_halted, out_br_timeout,
           out_instr_count, out_stall_count
  );

  modport slave (
    input  in_instr, in_instr_valid, in_ex_memRead, in_ex_operand, in_ex_resolved,
    output out_ctrl_cpin, out_ctrl_cpout, out_ctrl_memRead, out_ctrl_memWrite,
           out_ctrl_halt, out_ctrl_branch, out_ctrl_jump, out_ctrl_regWrite,
           out_ctrl_writeSrc, out_opcode, out_operand, out_sign, out_format,
           out_extended, out_flush, out_if_stall, out_halted, out_br_timeout,
           out_instr_count, out_stall_count
  );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Pure combinational instruction decoder: opcode/format to control bundle,
// plus the format-1 immediate extension. No state, no issue gating.
module decode_stage_instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [8:0]  instr_i,
  output ctrl_t       ctrl_o,
  output logic [15:0] extended_o
);

  // Opcode decode; unlisted opcodes are ALU/immediate ops writing a register
  always_comb begin
    ctrl_o = '0;
    case (instr_i[7:4])
      OP_LW: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.write_src = WS_MEM;
      end
      OP_SW:    ctrl_o.mem_write = 1'b1;
      OP_BR:    ctrl_o.branch    = 1'b1;
      OP_JMP:   ctrl_o.jump      = 1'b1;
      OP_HALT:  ctrl_o.halt      = 1'b1;
      OP_CPIN: begin
        ctrl_o.cpin      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.write_src = WS_COP;
      end
      OP_CPOUT: ctrl_o.cpout     = 1'b1;
      default: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.write_src = instr_i[8] ? WS_IMM : WS_ALU;
      end
    endcase
  end

  assign extended_o = extend_imm(instr_i[8], instr_i[3:0]);

endmodule

// File: rtl/decode_stage.sv
// IF/ID latch, decode, load-use / branch / halt hazard control and
// saturating performance counters feeding the ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned BR_TIMEOUT = 8
) (
  input logic          clock,
  input logic          reset_n,
  decode_stage_if.slave bus
);

  logic [8:0]  instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        br_timeout_q, br_timeout_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  ctrl_t       dec_ctrl;
  ctrl_t       ctrl_out;
  logic [15:0] dec_ext;
  logic        load_use;
  logic        issue;
  logic        if_stall;
  logic        flush;

  decode_stage_instr_decoder u_decoder (
    .instr_i    (instr_q),
    .ctrl_o     (dec_ctrl),
    .extended_o (dec_ext)
  );

  // Hazard detection: load-use only applies to format-0 (register) operands
  always_comb begin
    load_use = valid_q & bus.in_ex_memRead & ~instr_q[8] & (instr_q[2:0] == bus.in_ex_operand);
    issue    = valid_q & ~load_use & (state_q == ST_RUN);
    if_stall = load_use | (state_q != ST_RUN);
    flush    = ~issue;
  end

  // Controls reach ID/EX only on an issuing cycle; otherwise a bubble
  always_comb begin
    ctrl_out = issue ? dec_ctrl : '0;
  end

  // IF/ID latch: hold on stall; while waiting on a branch the fetched
  // instruction is wrong-path, so its valid bit is dropped
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    if (state_q == ST_BR_WAIT) begin
      valid_d = 1'b0;
    end else if (!if_stall) begin
      instr_d = bus.in_instr;
      valid_d = bus.in_instr_valid;
    end
  end

  // Hazard FSM: resolve beats timeout when both happen in the same cycle
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    br_timeout_d = br_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (issue && (dec_ctrl.branch || dec_ctrl.jump)) begin
          state_d = ST_BR_WAIT;
          wait_d  = 8'd0;
        end else if (issue && dec_ctrl.halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_BR_WAIT: begin
        if (bus.in_ex_resolved) begin
          state_d = ST_RUN;
        end else if (wait_q == 8'(BR_TIMEOUT - 1)) begin
          state_d      = ST_RUN;
          br_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Saturating counters for issued instructions and bubble cycles
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && (instr_cnt_q != 16'hFFFF)) begin
      instr_cnt_d = instr_cnt_q + 16'd1;
    end
    if (flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q      <= 9'd0;
      valid_q      <= 1'b0;
      state_q      <= ST_RUN;
      wait_q       <= 8'd0;
      br_timeout_q <= 1'b0;
      instr_cnt_q  <= 16'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      state_q      <= state_d;
      wait_q       <= wait_d;
      br_timeout_q <= br_timeout_d;
      instr_cnt_q  <= instr_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.out_ctrl_cpin     = ctrl_out.cpin;
  assign bus.out_ctrl_cpout    = ctrl_out.cpout;
  assign bus.out_ctrl_memRead  = ctrl_out.mem_read;
  assign bus.out_ctrl_memWrite = ctrl_out.mem_write;
  assign bus.out_ctrl_halt     = ctrl_out.halt;
  assign bus.out_ctrl_branch   = ctrl_out.branch;
  assign bus.out_ctrl_jump     = ctrl_out.jump;
  assign bus.out_ctrl_regWrite = ctrl_out.reg_write;
  assign bus.out_ctrl_writeSrc = ctrl_out.write_src;
  assign bus.out_opcode        = instr_q[7:4];
  assign bus.out_operand       = instr_q[2:0];
  assign bus.out_sign          = instr_q[3];
  assign bus.out_format        = instr_q[8];
  assign bus.out_extended      = dec_ext;
  assign bus.out_flush         = flush;
  assign bus.out_if_stall      = if_stall;
  assign bus.out_halted        = (state_q == ST_HALTED);
  assign bus.out_br_timeout    = br_timeout_q;
  assign bus.out_instr_count   = instr_cnt_q;
  assign bus.out_stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. Each cycle's stimulus carries the
// outputs expected during that same cycle; they go through a scoreboard
// queue and are compared after the combinational settle.
module tb_decode_stage;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_icnt = 16'd0;
  logic [15:0] exp_scnt = 16'd0;

  decode_stage_if bus ();

  decode_stage #(.BR_TIMEOUT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ctrl vector: {cpin, cpout, memRead, memWrite, halt, branch, jump, regWrite, writeSrc[1:0]}
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_ALU   = 10'b0000000100;
  localparam logic [9:0] C_IMM   = 10'b0000000110;
  localparam logic [9:0] C_LW    = 10'b0010000101;
  localparam logic [9:0] C_SW    = 10'b0001000000;
  localparam logic [9:0] C_BR    = 10'b0000010000;
  localparam logic [9:0] C_JMP   = 10'b0000001000;
  localparam logic [9:0] C_HALT  = 10'b0000100000;
  localparam logic [9:0] C_CPIN  = 10'b1000000111;
  localparam logic [9:0] C_CPOUT = 10'b0100000000;
  // flags: {flush, if_stall, halted, br_timeout}
  localparam logic [3:0] F_ISS = 4'b0000;
  localparam logic [3:0] F_BUB = 4'b1000;
  localparam logic [3:0] F_STL = 4'b1100;
  localparam logic [3:0] F_HLT = 4'b1110;
  localparam logic [3:0] F_TO  = 4'b0001;

  typedef struct {
    string       tag;
    logic [8:0]  instr;
    logic        valid;
    logic        mr;
    logic [2:0]  exop;
    logic        res;
    logic [13:0] vec;
    logic        chk;
    logic [15:0] ext;
  } stim_t;

  typedef struct {
    string       tag;
    logic [13:0] vec;
    logic        chk;
    logic [8:0]  dat;
    logic [15:0] ext;
  } exp_t;

  exp_t sb[$];

  function automatic stim_t st(input string tag, input logic [8:0] instr, input logic valid,
                               input logic mr, input logic [2:0] exop, input logic res,
                               input logic [9:0] ctrl, input logic [3:0] flags,
                               input logic chk, input logic [15:0] ext);
    stim_t s;
    s.tag = tag; s.instr = instr; s.valid = valid; s.mr = mr; s.exop = exop; s.res = res;
    s.vec = {ctrl, flags}; s.chk = chk; s.ext = ext;
    return s;
  endfunction

  function automatic logic [13:0] obs_vec();
    return {bus.out_ctrl_cpin, bus.out_ctrl_cpout, bus.out_ctrl_memRead, bus.out_ctrl_memWrite,
            bus.out_ctrl_halt, bus.out_ctrl_branch, bus.out_ctrl_jump, bus.out_ctrl_regWrite,
            bus.out_ctrl_writeSrc, bus.out_flush, bus.out_if_stall, bus.out_halted,
            bus.out_br_timeout};
  endfunction

  function automatic logic [24:0] obs_dat();
    return {bus.out_format, bus.out_opcode, bus.out_sign, bus.out_operand, bus.out_extended};
  endfunction

  // Drive one cycle of inputs; the expected data field is the instruction
  // latched by the previous cycle, recorded by the caller in s.chk/s.ext.
  logic [8:0] last_latched = 9'd0;
  task automatic drive(input stim_t s, input logic [8:0] dat);
    exp_t e;
    bus.in_instr       = s.instr;
    bus.in_instr_valid = s.valid;
    bus.in_ex_memRead  = s.mr;
    bus.in_ex_operand  = s.exop;
    bus.in_ex_resolved = s.res;
    e.tag = s.tag; e.vec = s.vec; e.chk = s.chk; e.dat = dat; e.ext = s.ext;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    drive(st("reset", 9'd0, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b1, 16'h0000), 9'd0);
    #2;
    e = sb.pop_front();
    checks++;
    if (obs_vec() !== e.vec) begin
      errors++; $display("FAIL %s flags got %h exp %h", e.tag, obs_vec(), e.vec);
    end
    checks++;
    if (obs_dat() !== {e.dat, e.ext}) begin
      errors++; $display("FAIL %s data got %h exp %h", e.tag, obs_dat(), {e.dat, e.ext});
    end
    checks++;
    if ({bus.out_instr_count, bus.out_stall_count} !== 32'd0) begin
      errors++; $display("FAIL %s counters got %h exp 0", e.tag,
                         {bus.out_instr_count, bus.out_stall_count});
    end
    exp_icnt = 16'd0;
    exp_scnt = 16'd0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    // The released cycle is a bubble and counts at the next edge
    exp_scnt = 16'd1;
    @(posedge clock); #1;
  endtask

  // Each test task runs its own table; data expectations for a cycle are
  // the instruction that its own table drove one cycle earlier.
  task automatic test_alu();
    stim_t q[$];
    exp_t e;
    logic [8:0] prev = 9'd0;
    q.push_back(st("alu_fill", 9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("alu_iss",  9'h046, 1'b1, 1'b1, 3'd4, 1'b0, C_ALU,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("alu_iss2", 9'h000, 1'b0, 1'b1, 3'd5, 1'b0, C_ALU,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("alu_idle", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    foreach (q[i]) begin
      drive(q[i], prev);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.vec) begin
        errors++; $display("FAIL %s flags got %h exp %h", e.tag, obs_vec(), e.vec);
      end
      if (e.chk) begin
        checks++;
        if (obs_dat() !== {e.dat, e.ext}) begin
          errors++; $display("FAIL %s data got %h exp %h", e.tag, obs_dat(), {e.dat, e.ext});
        end
      end
      checks++;
      if ({bus.out_instr_count, bus.out_stall_count} !== {exp_icnt, exp_scnt}) begin
        errors++; $display("FAIL %s counters got %h exp %h", e.tag,
                           {bus.out_instr_count, bus.out_stall_count}, {exp_icnt, exp_scnt});
      end
      if (e.vec[3]) exp_scnt++; else exp_icnt++;
      if (!(e.vec[3] && e.vec[2])) prev = q[i].instr;
      @(posedge clock); #1;
    end
  endtask

  task automatic run_table(input stim_t q[$], input logic [8:0] start);
    exp_t e;
    logic [8:0] prev = start;
    foreach (q[i]) begin
      drive(q[i], prev);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_vec() !== e.vec) begin
        errors++; $display("FAIL %s[%0d] flags got %h exp %h", e.tag, i, obs_vec(), e.vec);
      end
      if (e.chk) begin
        checks++;
        if (obs_dat() !== {e.dat, e.ext}) begin
          errors++; $display("FAIL %s[%0d] data got %h exp %h", e.tag, i, obs_dat(),
                             {e.dat, e.ext});
        end
      end
      checks++;
      if ({bus.out_instr_count, bus.out_stall_count} !== {exp_icnt, exp_scnt}) begin
        errors++; $display("FAIL %s[%0d] counters got %h exp %h", e.tag, i,
                           {bus.out_instr_count, bus.out_stall_count}, {exp_icnt, exp_scnt});
      end
      if (e.vec[3]) exp_scnt++; else exp_icnt++;
      // Latch advances only when fetch is not stalled
      if (!e.vec[2]) prev = q[i].instr;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    q.push_back(st("lu_fill",  9'h023, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("lu_stall", 9'h045, 1'b1, 1'b1, 3'd3, 1'b0, C_NONE, F_STL, 1'b1, 16'h0));
    q.push_back(st("lu_iss",   9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_ALU,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("lu_next",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_ALU,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("lu_idle",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    run_table(q, 9'h000);
  endtask

  task automatic test_branch();
    stim_t q[$];
    q.push_back(st("br_fill",  9'h0C0, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("br_iss",   9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_BR,   F_ISS, 1'b1, 16'h0));
    q.push_back(st("br_w1",    9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("br_w2",    9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("br_w3res", 9'h045, 1'b1, 1'b0, 3'd0, 1'b1, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("br_back",  9'h046, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("br_alu",   9'h0D0, 1'b1, 1'b0, 3'd0, 1'b0, C_ALU,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("jmp_iss",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_JMP,  F_ISS, 1'b1, 16'h0));
    q.push_back(st("jmp_w1",   9'h000, 1'b0, 1'b0, 3'd0, 1'b1, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("jmp_back", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    run_table(q, 9'h000);
  endtask

  // Resolve arriving on the same cycle the wait would time out
  task automatic test_resolve_at_limit();
    stim_t q[$];
    q.push_back(st("lim_fill", 9'h0C0, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("lim_iss",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_BR,   F_ISS, 1'b1, 16'h0));
    for (int k = 0; k < 7; k++)
      q.push_back(st("lim_wait", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("lim_res",  9'h000, 1'b0, 1'b0, 3'd0, 1'b1, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("lim_back", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    run_table(q, 9'h000);
  endtask

  task automatic test_timeout();
    stim_t q[$];
    q.push_back(st("to_fill", 9'h0C0, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("to_iss",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_BR,   F_ISS, 1'b1, 16'h0));
    for (int k = 0; k < 8; k++)
      q.push_back(st("to_wait", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_STL, 1'b0, 16'h0));
    q.push_back(st("to_exit", 9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB | F_TO, 1'b0, 16'h0));
    q.push_back(st("to_alu",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_ALU,  F_ISS | F_TO, 1'b1, 16'h0));
    q.push_back(st("to_idle", 9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB | F_TO, 1'b0, 16'h0));
    run_table(q, 9'h000);
  endtask

  // Halt is permanent until reset; a mid-run reset clears everything at once
  task automatic test_halt();
    stim_t q[$];
    q.push_back(st("h_fill", 9'h0F0, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB | F_TO, 1'b0, 16'h0));
    q.push_back(st("h_iss",  9'h045, 1'b1, 1'b0, 3'd0, 1'b0, C_HALT, F_ISS | F_TO, 1'b1, 16'h0));
    for (int k = 0; k < 4; k++)
      q.push_back(st("h_stay", 9'h045, 1'b1, 1'b0, 3'd0, 1'(k % 2), C_NONE, F_HLT | F_TO,
                     1'b0, 16'h0));
    run_table(q, 9'h000);
    test_reset();
  endtask

  task automatic test_ext_and_ops();
    stim_t q[$];
    q.push_back(st("x_fill",  9'h12A, 1'b1, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    q.push_back(st("x_neg",   9'h122, 1'b1, 1'b1, 3'd2, 1'b0, C_IMM,  F_ISS, 1'b1, 16'hFFFA));
    q.push_back(st("x_pos",   9'h083, 1'b1, 1'b0, 3'd0, 1'b0, C_IMM,  F_ISS, 1'b1, 16'h0002));
    q.push_back(st("x_lw",    9'h060, 1'b1, 1'b0, 3'd0, 1'b0, C_LW,   F_ISS, 1'b1, 16'h0000));
    q.push_back(st("x_cpin",  9'h070, 1'b1, 1'b0, 3'd0, 1'b0, C_CPIN, F_ISS, 1'b1, 16'h0000));
    q.push_back(st("x_cpout", 9'h090, 1'b1, 1'b0, 3'd0, 1'b0, C_CPOUT, F_ISS, 1'b1, 16'h0000));
    q.push_back(st("x_sw",    9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_SW,   F_ISS, 1'b1, 16'h0000));
    q.push_back(st("x_idle",  9'h000, 1'b0, 1'b0, 3'd0, 1'b0, C_NONE, F_BUB, 1'b0, 16'h0));
    run_table(q, 9'h000);
  endtask

  initial begin
    bus.in_instr       = 9'd0;
    bus.in_instr_valid = 1'b0;
    bus.in_ex_memRead  = 1'b0;
    bus.in_ex_operand  = 3'd0;
    bus.in_ex_resolved = 1'b0;
    reset_n            = 1'b0;
    test_reset();
    test_alu();
    test_load_use();
    test_branch();
    test_resolve_at_limit();
    test_timeout();
    test_halt();
    test_ext_and_ops();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
